// File: rtl/wb_trace_checker.sv
// wb_trace_checker: compares each retired register write, in order, against a preloaded expected trace
module wb_trace_checker #(
  parameter int DEPTH = 16,
  parameter int RW = 5,
  parameter int DW = 32,
  parameter int TIMEOUT = 1000,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          exp_wr_en,
  input  logic [AW-1:0] exp_wr_idx,
  input  logic [RW-1:0] exp_wr_reg,
  input  logic [DW-1:0] exp_wr_data,
  input  logic [CW-1:0] exp_count,
  input  logic          start,
  input  logic          wb_valid,
  input  logic [RW-1:0] wb_reg,
  input  logic [DW-1:0] wb_data,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic          timeout,
  output logic [CW-1:0] match_count,
  output logic [CW-1:0] mismatch_count,
  output logic [AW-1:0] first_err_idx
);
  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
  localparam logic [CW-1:0] ONE = CW'(1);
  state_t state, state_n;
  logic [RW+DW-1:0] tbl [DEPTH];
  logic [CW-1:0] ptr, n_q, n;
  logic [16:0] idle, idle_inc;
  logic launch, consume, hit, last, tick, expire;
  assign n = (exp_count > CW'(DEPTH)) ? CW'(DEPTH) : exp_count;
  assign launch = start && state != RUN;
  assign consume = state == RUN && ce && wb_valid && wb_reg != '0;
  assign hit = {wb_reg, wb_data} == tbl[ptr[AW-1:0]];
  assign last = (ptr + ONE) == n_q;
  assign tick = state == RUN && ce && !consume;
  assign idle_inc = idle + 17'd1;
  assign expire = tick && idle_inc == 17'(TIMEOUT);
  assign busy = state == RUN;
  assign pass = state == PASS;
  assign fail = state == FAIL;
  assign done = pass || fail;
  always_ff @(posedge clk)
    if (exp_wr_en && state != RUN) tbl[exp_wr_idx] <= {exp_wr_reg, exp_wr_data};
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (launch) state_n = (n == '0) ? PASS : RUN;
    else if (consume && last) state_n = (hit && mismatch_count == '0) ? PASS : FAIL;
    else if (expire) state_n = FAIL;
  end
  always_ff @(posedge clk)
    if (rst || launch) begin
      ptr <= '0;
      match_count <= '0;
      mismatch_count <= '0;
      first_err_idx <= '0;
      timeout <= 1'b0;
      idle <= '0;
      n_q <= rst ? '0 : n;
    end else if (consume) begin
      ptr <= ptr + ONE;
      idle <= '0;
      match_count <= hit ? match_count + ONE : match_count;
      mismatch_count <= hit ? mismatch_count : mismatch_count + ONE;
      first_err_idx <= (!hit && mismatch_count == '0) ? ptr[AW-1:0] : first_err_idx;
    end else if (tick) begin
      idle <= idle_inc;
      timeout <= timeout | expire;
    end
endmodule

// File: tb/tb_wb_trace_checker.sv
// tb_wb_trace_checker: directed scenarios plus randomized runs scored against a trace model
module tb_wb_trace_checker;
  logic clk = 1'b0, rst, ce, exp_wr_en, start, wb_valid;
  logic [3:0] exp_wr_idx, first_err_idx;
  logic [4:0] exp_wr_reg, exp_count, wb_reg, match_count, mismatch_count;
  logic [31:0] exp_wr_data, wb_data;
  logic busy, done, pass, fail, timeout;
  logic [4:0] mreg [16];
  logic [31:0] mdata [16];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  wb_trace_checker #(.DEPTH(16), .RW(5), .DW(32), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .ce(ce), .exp_wr_en(exp_wr_en), .exp_wr_idx(exp_wr_idx),
    .exp_wr_reg(exp_wr_reg), .exp_wr_data(exp_wr_data), .exp_count(exp_count),
    .start(start), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .match_count(match_count), .mismatch_count(mismatch_count), .first_err_idx(first_err_idx)
  );

  task automatic load(input int i, input logic [4:0] r, input logic [31:0] d, input bit upd);
    exp_wr_en = 1'b1; exp_wr_idx = 4'(i); exp_wr_reg = r; exp_wr_data = d;
    @(negedge clk);
    exp_wr_en = 1'b0;
    if (upd) begin mreg[i] = r; mdata[i] = d; end
  endtask

  task automatic load_std();
    load(0, 5'd8, 32'd5, 1'b1);
    load(1, 5'd9, 32'd7, 1'b1);
    load(2, 5'd10, 32'd12, 1'b1);
    exp_count = 5'd3;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1'b1; wb_reg = r; wb_data = d;
    @(negedge clk);
    wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; exp_wr_en = 0; exp_wr_idx = 0; exp_wr_reg = 0; exp_wr_data = 0;
    exp_count = 0; start = 0; wb_valid = 0; wb_reg = 0; wb_data = 0;
    repeat (2) @(negedge clk);
    checks++; if ({busy, done, pass, fail, timeout} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {busy, done, pass, fail, timeout}); end
    checks++; if ({match_count, mismatch_count, first_err_idx} !== 14'b0) begin errors++; $display("FAIL reset_counts got %0d/%0d/%0d exp 0/0/0", match_count, mismatch_count, first_err_idx); end
    rst = 1'b0;
  endtask

  task automatic test_match();
    load_std();
    do_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy got %b exp 1", busy); end
    wb(5'd8, 32'd5);
    wb(5'd9, 32'd7);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL t1_mid got busy=%b done=%b exp 1 0", busy, done); end
    wb(5'd10, 32'd12);
    checks++; if (pass !== 1'b1 || fail !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL t1_pass got pass=%b fail=%b done=%b exp 1 0 1", pass, fail, done); end
    checks++; if (match_count !== 5'd3 || mismatch_count !== 5'd0) begin errors++; $display("FAIL t1_counts got %0d/%0d exp 3/0", match_count, mismatch_count); end
  endtask

  task automatic test_mismatch();
    do_start();
    wb(5'd8, 32'd5);
    wb(5'd9, 32'd8);
    wb(5'd10, 32'd12);
    checks++; if (fail !== 1'b1 || pass !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL t2_fail got fail=%b pass=%b timeout=%b exp 1 0 0", fail, pass, timeout); end
    checks++; if (match_count !== 5'd2 || mismatch_count !== 5'd1) begin errors++; $display("FAIL t2_counts got %0d/%0d exp 2/1", match_count, mismatch_count); end
    checks++; if (first_err_idx !== 4'd1) begin errors++; $display("FAIL t2_first_err got %0d exp 1", first_err_idx); end
    wb(5'd8, 32'd5);
    checks++; if (fail !== 1'b1 || match_count !== 5'd2) begin errors++; $display("FAIL t2_hold got fail=%b match=%0d exp 1 2", fail, match_count); end
  endtask

  task automatic test_ignored();
    do_start();
    wb(5'd0, 32'd99);
    @(negedge clk);
    wb(5'd8, 32'd5);
    wb(5'd0, 32'd99);
    wb(5'd9, 32'd7);
    @(negedge clk);
    wb(5'd0, 32'd99);
    wb(5'd10, 32'd12);
    checks++; if (pass !== 1'b1 || match_count !== 5'd3 || mismatch_count !== 5'd0) begin errors++; $display("FAIL t3_pass got pass=%b %0d/%0d exp 1 3/0", pass, match_count, mismatch_count); end
  endtask

  task automatic test_timeout();
    do_start();
    ce = 1'b0; wb_valid = 1'b1; wb_reg = 5'd8; wb_data = 32'd5;
    repeat (50) @(negedge clk);
    checks++; if (busy !== 1'b1 || match_count !== 5'd0 || timeout !== 1'b0) begin errors++; $display("FAIL t4_frozen got busy=%b match=%0d timeout=%b exp 1 0 0", busy, match_count, timeout); end
    ce = 1'b1; wb_valid = 1'b0; wb_reg = 0; wb_data = 0;
    repeat (19) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t4_before got busy=%b exp 1", busy); end
    @(negedge clk);
    checks++; if (fail !== 1'b1 || timeout !== 1'b1) begin errors++; $display("FAIL t4_timeout got fail=%b timeout=%b exp 1 1", fail, timeout); end
    do_start();
    repeat (19) @(negedge clk);
    wb(5'd8, 32'd5);
    checks++; if (busy !== 1'b1 || fail !== 1'b0 || match_count !== 5'd1) begin errors++; $display("FAIL t4_consume_wins got busy=%b fail=%b match=%0d exp 1 0 1", busy, fail, match_count); end
    repeat (19) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t4_timer_cleared got busy=%b exp 1", busy); end
    wb(5'd9, 32'd7);
    wb(5'd10, 32'd12);
    checks++; if (pass !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL t4_finish got pass=%b timeout=%b exp 1 0", pass, timeout); end
  endtask

  task automatic test_reset_mid();
    do_start();
    wb(5'd8, 32'd5);
    checks++; if (match_count !== 5'd1) begin errors++; $display("FAIL t5_one got %0d exp 1", match_count); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({busy, done, pass, fail, timeout, match_count, mismatch_count, first_err_idx} !== 19'b0) begin errors++; $display("FAIL t5_reset got busy=%b done=%b match=%0d exp all 0", busy, done, match_count); end
    do_start();
    wb(5'd8, 32'd5);
    wb(5'd9, 32'd7);
    wb(5'd10, 32'd12);
    checks++; if (pass !== 1'b1 || match_count !== 5'd3) begin errors++; $display("FAIL t5_pass got pass=%b match=%0d exp 1 3", pass, match_count); end
  endtask

  task automatic test_zero_count();
    exp_count = 5'd0;
    do_start();
    checks++; if (pass !== 1'b1 || busy !== 1'b0 || match_count !== 5'd0) begin errors++; $display("FAIL t6_zero got pass=%b busy=%b exp 1 0", pass, busy); end
    exp_count = 5'd3;
    do_start();
    load(1, 5'd9, 32'd77, 1'b0);
    wb(5'd8, 32'd5);
    wb(5'd9, 32'd7);
    wb(5'd10, 32'd12);
    checks++; if (pass !== 1'b1 || match_count !== 5'd3) begin errors++; $display("FAIL t6_run_write got pass=%b match=%0d exp 1 3", pass, match_count); end
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 16; i++) load(i, 5'($urandom_range(1, 31)), $urandom, 1'b1);
    exp_count = 5'd31;
    do_start();
    for (int i = 0; i < 15; i++) wb(mreg[i], mdata[i]);
    checks++; if (busy !== 1'b1 || match_count !== 5'd15) begin errors++; $display("FAIL clamp_mid got busy=%b match=%0d exp 1 15", busy, match_count); end
    wb(mreg[15], mdata[15]);
    checks++; if (pass !== 1'b1 || match_count !== 5'd16) begin errors++; $display("FAIL clamp_end got pass=%b match=%0d exp 1 16", pass, match_count); end
  endtask

  task automatic test_random();
    int n, em, emm, efe, gaps;
    bit bad;
    logic [4:0] r;
    logic [31:0] d;
    for (int run = 0; run < 12; run++) begin
      n = $urandom_range(1, 16); em = 0; emm = 0; efe = -1;
      for (int i = 0; i < n; i++) load(i, 5'($urandom_range(1, 31)), $urandom, 1'b1);
      exp_count = 5'(n);
      do_start();
      for (int i = 0; i < n; i++) begin
        gaps = $urandom_range(0, 3);
        for (int g = 0; g < gaps; g++) begin
          case ($urandom_range(0, 2))
            0: wb_valid = 1'b0;
            1: begin wb_valid = 1'b1; wb_reg = 5'd0; wb_data = $urandom; end
            default: begin ce = 1'b0; wb_valid = 1'b1; wb_reg = 5'($urandom_range(1, 31)); wb_data = $urandom; end
          endcase
          @(negedge clk);
          ce = 1'b1; wb_valid = 1'b0;
        end
        r = mreg[i]; d = mdata[i];
        bad = $urandom_range(0, 3) == 0;
        if (bad) begin
          if ($urandom_range(0, 1) == 1) r = 5'((int'(r) % 31) + 1);
          else d = d ^ ($urandom | 32'd1);
          emm++;
          if (efe < 0) efe = i;
        end else em++;
        wb(r, d);
      end
      checks++; if (pass !== (emm == 0) || fail !== (emm != 0) || timeout !== 1'b0) begin errors++; $display("FAIL rand%0d_state got pass=%b fail=%b timeout=%b exp pass=%b", run, pass, fail, timeout, emm == 0); end
      checks++; if (match_count !== 5'(em) || mismatch_count !== 5'(emm)) begin errors++; $display("FAIL rand%0d_counts got %0d/%0d exp %0d/%0d", run, match_count, mismatch_count, em, emm); end
      if (emm > 0) begin
        checks++; if (first_err_idx !== 4'(efe)) begin errors++; $display("FAIL rand%0d_first_err got %0d exp %0d", run, first_err_idx, efe); end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_match();
    test_mismatch();
    test_ignored();
    test_timeout();
    test_reset_mid();
    test_zero_count();
    test_clamp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
